// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer.
//   state_e   : FSM state encoding (idle / shifting)
//   cnt_width : width of the remaining-bit counter for a given word width
package bit_serializer_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    // Counter holds WIDTH-1 down to 0; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/word_hold_buf.sv
// One-word hold buffer with a full flag.
//   clk, rst : clock, synchronous active-high reset
//   wr, wdata: write strobe and word; sets full
//   rd       : read strobe; clears full (write wins if both asserted)
//   rdata    : stored word
//   full     : buffer holds a word
module word_hold_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             full
);

    logic [WIDTH-1:0] data_q;
    logic             full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            if (wr) begin
                data_q <= wdata;
                full_q <= 1'b1;
            end else if (rd) begin
                full_q <= 1'b0;
            end
        end
    end

    assign rdata = data_q;
    assign full  = full_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words on a valid/ready
// handshake and emits one bit per clock. A one-word hold buffer lets
// consecutive words stream without bubble cycles.
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : parallel word, sampled only on an accept edge
//   in_valid   : in_data valid
//   in_ready   : a word can be accepted (hold buffer empty)
//   dout       : serial bit
//   dout_valid : dout carries a word bit
//   last_bit   : dout is the final bit of its word
//   busy       : shifting or hold buffer occupied
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int unsigned     CntW   = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             hwr, hrd, hfull, hfull_next;
    logic [WIDTH-1:0] hdata;
    logic [WIDTH-1:0] shifted;

    word_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk   (clk),
        .rst   (rst),
        .wr    (hwr),
        .wdata (in_data),
        .rd    (hrd),
        .rdata (hdata),
        .full  (hfull)
    );

    assign accept = in_valid & ~hfull;

    // Shift toward the output end, zero-filling behind.
    always_comb begin
        if (MSB_FIRST) begin
            shifted = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {1'b0, sreg_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        hwr     = 1'b0;
        hrd     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sreg_d  = in_data;
                    cnt_d   = CntMax;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q != '0) begin
                    sreg_d = shifted;
                    cnt_d  = cnt_q - CntW'(1);
                    hwr    = accept;
                end else if (hfull) begin
                    // Buffered word follows the last bit directly.
                    sreg_d = hdata;
                    cnt_d  = CntMax;
                    hrd    = 1'b1;
                end else if (accept) begin
                    // Bypass: incoming word goes straight to the shifter.
                    sreg_d = in_data;
                    cnt_d  = CntMax;
                end else begin
                    // Clearing sreg keeps dout low while idle.
                    sreg_d  = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign hfull_next = hwr | (hfull & ~hrd);
    assign last_d     = (state_d == StShift) && (cnt_d == '0);
    assign busy_d     = (state_d == StShift) | hfull_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sreg_q  <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign dout       = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    assign dout_valid = (state_q == StShift);
    assign last_bit   = last_q;
    assign busy       = busy_q;
    assign in_ready   = ~hfull;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed and random stimulus for an MSB-first and an LSB-first instance.
// Accepted words are expanded into expected bits on a scoreboard queue;
// every cycle the serial outputs are checked against the queue head.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dm, dl;
    logic       vm, vl;
    logic       rdym, doutm, dvm, lastm, busym;
    logic       rdyl, doutl, dvl, lastl, busyl;

    logic [1:0] qm[$];
    logic [1:0] ql[$];
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    bit_serializer #(
        .WIDTH     (8),
        .MSB_FIRST (1'b1)
    ) u_msb (
        .clk        (clk),
        .rst        (rst),
        .in_data    (dm),
        .in_valid   (vm),
        .in_ready   (rdym),
        .dout       (doutm),
        .dout_valid (dvm),
        .last_bit   (lastm),
        .busy       (busym)
    );

    bit_serializer #(
        .WIDTH     (8),
        .MSB_FIRST (1'b0)
    ) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .in_data    (dl),
        .in_valid   (vl),
        .in_ready   (rdyl),
        .dout       (doutl),
        .dout_valid (dvl),
        .last_bit   (lastl),
        .busy       (busyl)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // {last, bit} for bit position i of a word in transmit order.
    function automatic logic [1:0] exp_bit(input logic [7:0] d, input bit msb, input int i);
        logic b;
        b = msb ? d[7 - i] : d[i];
        return {(i == 7), b};
    endfunction

    // sz is the queue depth including the bit expected now; a full hold
    // buffer means more than one word of bits is pending.
    task automatic mon(input string tag, input logic dv, input logic d, input logic lb,
                       input logic by, input logic rdy, input int sz, input logic [1:0] em);
        chk({tag, "_valid"}, 32'(dv), 32'(sz != 0));
        chk({tag, "_busy"}, 32'(by), 32'(sz != 0));
        chk({tag, "_ready"}, 32'(rdy), 32'(sz <= 8));
        chk({tag, "_dout"}, 32'(d), 32'(em[0]));
        chk({tag, "_last"}, 32'(lb), 32'(em[1]));
    endtask

    // One clock: note accepts before the edge, update scoreboard, then
    // check outputs on the falling edge.
    task automatic cycle();
        logic       am, al, rs;
        logic [7:0] sdm, sdl;
        logic [1:0] em, el;
        int         szm, szl;
        rs  = rst;
        am  = (vm === 1'b1) && (rdym === 1'b1);
        al  = (vl === 1'b1) && (rdyl === 1'b1);
        sdm = dm;
        sdl = dl;
        @(posedge clk);
        if (rs === 1'b1) begin
            qm.delete();
            ql.delete();
        end else begin
            if (am) for (int i = 0; i < 8; i++) qm.push_back(exp_bit(sdm, 1'b1, i));
            if (al) for (int i = 0; i < 8; i++) ql.push_back(exp_bit(sdl, 1'b0, i));
        end
        @(negedge clk);
        szm = qm.size();
        szl = ql.size();
        em  = (szm != 0) ? qm.pop_front() : 2'b00;
        el  = (szl != 0) ? ql.pop_front() : 2'b00;
        mon("msb", dvm, doutm, lastm, busym, rdym, szm, em);
        mon("lsb", dvl, doutl, lastl, busyl, rdyl, szl, el);
    endtask

    initial begin
        rst = 1'b1;
        vm  = 1'b0;
        vl  = 1'b0;
        dm  = 8'h00;
        dl  = 8'h00;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Single word A5, MSB first
        vm = 1'b1; dm = 8'hA5;
        cycle();
        vm = 1'b0;
        repeat (10) cycle();

        // Back-to-back A5, 3C with in_valid held
        vm = 1'b1; dm = 8'hA5;
        cycle();
        dm = 8'h3C;
        cycle();
        vm = 1'b0;
        repeat (18) cycle();

        // Bypass: FF presented at the last-bit edge of A5
        vm = 1'b1; dm = 8'hA5;
        cycle();
        vm = 1'b0;
        repeat (7) cycle();
        vm = 1'b1; dm = 8'hFF;
        cycle();
        vm = 1'b0;
        repeat (10) cycle();

        // Reset after the third bit, then 55
        vm = 1'b1; dm = 8'hA5;
        cycle();
        vm = 1'b0;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        vm = 1'b1; dm = 8'h55;
        cycle();
        vm = 1'b0;
        repeat (10) cycle();

        // LSB first: 01
        vl = 1'b1; dl = 8'h01;
        cycle();
        vl = 1'b0;
        repeat (10) cycle();

        // Detector pattern stream: AA then 52
        vm = 1'b1; dm = 8'hAA;
        cycle();
        dm = 8'h52;
        cycle();
        vm = 1'b0;
        repeat (18) cycle();

        // Random traffic on both instances
        for (int n = 0; n < 80; n++) begin
            vm = ($urandom_range(0, 2) != 0);
            vl = ($urandom_range(0, 2) != 0);
            dm = 8'($urandom);
            dl = 8'($urandom);
            cycle();
        end
        vm = 1'b0;
        vl = 1'b0;
        repeat (20) cycle();

        chk("msb_queue_empty", 32'(qm.size()), 32'd0);
        chk("lsb_queue_empty", 32'(ql.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
